// File: rtl/sifive_insight_tl_d_user_capture.sv
`default_nettype none
// ============================================================================
// Module   : sifive_insight_tl_d_user_capture
// Brief    : Passive TileLink D-channel monitor; one FIFO record per completed
//            D message (user first/OR, beats, flags). Optional drop counter
//            enabled by macro SIFIVE_INSIGHT_DUSER_DROPCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sifive_insight_tl_d_user_capture #(
    parameter int USER_W          = 8,
    parameter int SOURCE_W        = 4,
    parameter int SIZE_W          = 4,
    parameter int BEAT_BYTES_LOG2 = 3,
    parameter int MAX_BEATS_LOG2  = 3,
    parameter int DEPTH           = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         d_valid,
    input  logic                         d_ready,
    input  logic [2:0]                   d_opcode,
    input  logic [SIZE_W-1:0]            d_size,
    input  logic [SOURCE_W-1:0]          d_source,
    input  logic [USER_W-1:0]            d_user,
    input  logic                         d_denied,
    input  logic                         d_corrupt,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [SOURCE_W-1:0]          rec_source,
    output logic [2:0]                   rec_opcode,
    output logic [USER_W-1:0]            rec_user_first,
    output logic [USER_W-1:0]            rec_user_or,
    output logic [MAX_BEATS_LOG2:0]      rec_beats,
    output logic                         rec_denied,
    output logic                         rec_corrupt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
`ifdef SIFIVE_INSIGHT_DUSER_DROPCNT_EN
    output logic [15:0]                  drop_count,
`endif
    input  logic                         clear_overflow
);

    localparam int c_BW    = MAX_BEATS_LOG2 + 1;
    localparam int c_PW    = $clog2(DEPTH);
    localparam int c_LW    = $clog2(DEPTH + 1);
    localparam int c_REC_W = SOURCE_W + 3 + 2 * USER_W + c_BW + 2;
    localparam logic [c_BW-1:0]   c_MAX_BEATS = c_BW'(2 ** MAX_BEATS_LOG2);
    localparam logic [SIZE_W-1:0] c_BBL2      = SIZE_W'(BEAT_BYTES_LOG2);
    localparam logic [SIZE_W-1:0] c_MBL2      = SIZE_W'(MAX_BEATS_LOG2);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                r_state;
    logic [SOURCE_W-1:0]   r_src;
    logic [2:0]            r_op;
    logic [USER_W-1:0]     r_uf;
    logic [USER_W-1:0]     r_uor;
    logic [c_BW-1:0]       r_beats;
    logic [c_BW-1:0]       r_exp;
    logic                  r_den;
    logic                  r_cor;

    logic [c_REC_W-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0]       r_wptr;
    logic [c_PW-1:0]       r_rptr;
    logic [c_LW-1:0]       r_count;
    logic                  r_overflow;

    logic                  w_fire;
    logic                  w_is_data;
    logic [SIZE_W-1:0]     w_shift;
    logic [c_BW-1:0]       w_exp;
    logic                  w_push;
    logic [SOURCE_W-1:0]   w_src;
    logic [2:0]            w_op;
    logic [USER_W-1:0]     w_uf;
    logic [USER_W-1:0]     w_uor;
    logic [c_BW-1:0]       w_beats;
    logic                  w_den;
    logic                  w_cor;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;

    assign w_fire    = d_valid & d_ready;
    assign w_is_data = (d_opcode == 3'd1) || (d_opcode == 3'd5);
    assign w_shift   = d_size - c_BBL2;

    // Beats expected for a message starting with the current beat
    always_comb begin
        w_exp = c_BW'(1);
        if (w_is_data && (d_size > c_BBL2)) begin
            if (w_shift >= c_MBL2) begin
                w_exp = c_MAX_BEATS;
            end else begin
                w_exp = c_BW'(1) << w_shift;
            end
        end
    end

    // Record as it would stand after the current beat is folded in
    always_comb begin
        w_src   = d_source;
        w_op    = d_opcode;
        w_uf    = d_user;
        w_uor   = d_user;
        w_beats = c_BW'(1);
        w_den   = d_denied;
        w_cor   = d_corrupt;
        w_push  = w_fire && (w_exp == c_BW'(1));
        if (r_state == BURST) begin
            w_src   = r_src;
            w_op    = r_op;
            w_uf    = r_uf;
            w_uor   = r_uor | d_user;
            w_beats = r_beats + c_BW'(1);
            w_den   = r_den | d_denied;
            w_cor   = r_cor | d_corrupt;
            w_push  = w_fire && ((r_beats + c_BW'(1)) == r_exp);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_op    <= '0;
            r_uf    <= '0;
            r_uor   <= '0;
            r_beats <= '0;
            r_exp   <= '0;
            r_den   <= 1'b0;
            r_cor   <= 1'b0;
        end else if (w_fire) begin
            r_src   <= w_src;
            r_op    <= w_op;
            r_uf    <= w_uf;
            r_uor   <= w_uor;
            r_beats <= w_beats;
            r_den   <= w_den;
            r_cor   <= w_cor;
            if (r_state == IDLE) begin
                r_exp   <= w_exp;
                r_state <= w_push ? IDLE : BURST;
            end else if (w_push) begin
                r_state <= IDLE;
            end
        end
    end

    assign rec_valid = (r_count != '0);
    assign w_pop     = rec_valid & rec_ready;
    assign w_full    = (r_count == c_LW'(DEPTH));
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wptr] <= {w_src, w_op, w_uf, w_uor, w_beats, w_den, w_cor};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + c_LW'(1);
            end else if (w_pop && !w_wr) begin
                r_count <= r_count - c_LW'(1);
            end
            // A drop in the same cycle as a clear keeps the flag set
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign {rec_source, rec_opcode, rec_user_first, rec_user_or,
            rec_beats, rec_denied, rec_corrupt} = r_mem[r_rptr];
    assign level    = r_count;
    assign overflow = r_overflow;

`ifdef SIFIVE_INSIGHT_DUSER_DROPCNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            if (clear_overflow) begin
                r_drop_count <= 16'd1;
            end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end else if (clear_overflow) begin
            r_drop_count <= '0;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sifive_insight_tl_d_user_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sifive_insight_tl_d_user_capture
// Brief    : Directed + randomized bench with a queue-based message model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sifive_insight_tl_d_user_capture;

    localparam int USER_W = 8, SOURCE_W = 4, SIZE_W = 4;
    localparam int BBL2 = 3, MBL2 = 3, DEPTH = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset_n = 1'b0;
    logic                 d_valid = 0, d_ready = 0, d_denied = 0, d_corrupt = 0;
    logic [2:0]           d_opcode = 0;
    logic [SIZE_W-1:0]    d_size = 0;
    logic [SOURCE_W-1:0]  d_source = 0;
    logic [USER_W-1:0]    d_user = 0;
    logic                 rec_ready = 0, clear_overflow = 0;
    logic                 rec_valid, rec_denied, rec_corrupt, overflow;
    logic [SOURCE_W-1:0]  rec_source;
    logic [2:0]           rec_opcode;
    logic [USER_W-1:0]    rec_user_first, rec_user_or;
    logic [MBL2:0]        rec_beats;
    logic [$clog2(DEPTH+1)-1:0] level;
`ifdef SIFIVE_INSIGHT_DUSER_DROPCNT_EN
    logic [15:0]          drop_count;
`endif

    sifive_insight_tl_d_user_capture #(
        .USER_W(USER_W), .SOURCE_W(SOURCE_W), .SIZE_W(SIZE_W),
        .BEAT_BYTES_LOG2(BBL2), .MAX_BEATS_LOG2(MBL2), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_size(d_size), .d_source(d_source), .d_user(d_user),
        .d_denied(d_denied), .d_corrupt(d_corrupt),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_source(rec_source), .rec_opcode(rec_opcode),
        .rec_user_first(rec_user_first), .rec_user_or(rec_user_or),
        .rec_beats(rec_beats), .rec_denied(rec_denied), .rec_corrupt(rec_corrupt),
        .level(level), .overflow(overflow),
`ifdef SIFIVE_INSIGHT_DUSER_DROPCNT_EN
        .drop_count(drop_count),
`endif
        .clear_overflow(clear_overflow)
    );

    typedef struct {
        int src; int op; int uf; int uor; int beats; int den; int cor;
    } rec_t;

    rec_t mq[$];
    rec_t cur;
    bit   busy;
    int   cur_exp;
    bit   m_ov;
    int   m_dc;
    int   errors = 0;
    int   checks = 0;

    function automatic int exp_beats(int op, int sz);
        int n;
        if ((op == 1 || op == 5) && sz > BBL2) begin
            n = 1 << (sz - BBL2);
            return (n > (1 << MBL2)) ? (1 << MBL2) : n;
        end
        return 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("rec_valid", rec_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ov);
`ifdef SIFIVE_INSIGHT_DUSER_DROPCNT_EN
        chk("drop_count", drop_count, m_dc);
`endif
        if (mq.size() != 0) begin
            chk("rec_source", rec_source, mq[0].src);
            chk("rec_opcode", rec_opcode, mq[0].op);
            chk("rec_user_first", rec_user_first, mq[0].uf);
            chk("rec_user_or", rec_user_or, mq[0].uor);
            chk("rec_beats", rec_beats, mq[0].beats);
            chk("rec_denied", rec_denied, mq[0].den);
            chk("rec_corrupt", rec_corrupt, mq[0].cor);
        end
    endtask

    // Drive one cycle, advance the model over that cycle, then compare
    task automatic step(input bit v, input bit r, input int op, input int sz,
                        input int src, input int usr, input bit den, input bit cor,
                        input bit rr, input bit clr);
        bit push, pop, drop;
        int sizeb;
        d_valid = v; d_ready = r; d_opcode = op[2:0]; d_size = sz[SIZE_W-1:0];
        d_source = src[SOURCE_W-1:0]; d_user = usr[USER_W-1:0];
        d_denied = den; d_corrupt = cor; rec_ready = rr; clear_overflow = clr;
        push = 0; drop = 0;
        pop = (mq.size() != 0) && rr;
        if (v && r) begin
            if (!busy) begin
                cur = '{src, op, usr, usr, 1, den, cor};
                cur_exp = exp_beats(op, sz);
                if (cur_exp == 1) push = 1; else busy = 1;
            end else begin
                cur.uor |= usr; cur.den |= den; cur.cor |= cor; cur.beats++;
                if (cur.beats == cur_exp) begin push = 1; busy = 0; end
            end
        end
        sizeb = mq.size();
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (sizeb == DEPTH && !pop) drop = 1;
            else mq.push_back(cur);
        end
        if (drop) m_ov = 1; else if (clr) m_ov = 0;
        if (drop) m_dc = clr ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
        else if (clr) m_dc = 0;
        @(posedge clock); #1;
        compare_model();
    endtask

    task automatic idle(input bit rr, input bit clr);
        step(0, 0, 0, 0, 0, 0, 0, 0, rr, clr);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        d_valid = 0; d_ready = 0; rec_ready = 0; clear_overflow = 0;
        mq.delete(); busy = 0; m_ov = 0; m_dc = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        compare_model();
    endtask

    initial begin
        int pct;
        do_reset();
        chk("reset_rec_valid", rec_valid, 0);
        chk("reset_level", level, 0);
        chk("reset_overflow", overflow, 0);

        // Single-beat AccessAck
        step(1, 1, 0, 3, 3, 8'h5A, 0, 0, 0, 0);
        chk("single_valid", rec_valid, 1);
        chk("single_beats", rec_beats, 1);
        chk("single_uf", rec_user_first, 8'h5A);
        chk("single_uor", rec_user_or, 8'h5A);
        chk("single_level", level, 1);
        idle(1, 0);

        // Four-beat AccessAckData with corrupt on beat 3
        step(1, 1, 1, 5, 2, 8'h01, 0, 0, 0, 0);
        step(1, 1, 1, 5, 2, 8'h02, 0, 0, 0, 0);
        step(1, 1, 1, 5, 2, 8'h04, 0, 1, 0, 0);
        chk("burst_pending_level", level, 0);
        step(1, 1, 1, 5, 2, 8'h80, 0, 0, 0, 0);
        chk("burst_beats", rec_beats, 4);
        chk("burst_uf", rec_user_first, 8'h01);
        chk("burst_uor", rec_user_or, 8'h87);
        chk("burst_corrupt", rec_corrupt, 1);
        idle(1, 0);

        // Overflow: six messages into a four-deep FIFO
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, i, i + 16, 0, 0, 0, 0);
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
`ifdef SIFIVE_INSIGHT_DUSER_DROPCNT_EN
        chk("ovf_drop_count", drop_count, 2);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", rec_source, i);
            idle(1, 0);
        end
        idle(0, 1);
        chk("ovf_cleared", overflow, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, i, 8'h40 + i, 0, 0, 0, 0);
        step(1, 1, 0, 0, 9, 8'h33, 0, 0, 1, 0);
        chk("fullpop_level", level, 4);
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_head", rec_source, 1);
        for (int i = 0; i < 4; i++) idle(1, 0);

        // Drop coinciding with clear_overflow
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, i, i, 0, 0, 0, 0);
        step(1, 1, 0, 0, 5, 8'h77, 0, 0, 0, 1);
        chk("collide_ovf", overflow, 1);
`ifdef SIFIVE_INSIGHT_DUSER_DROPCNT_EN
        chk("collide_drop_count", drop_count, 1);
`endif
        for (int i = 0; i < 4; i++) idle(1, 0);
        idle(0, 1);

        // Reset mid-burst discards the partial message
        step(1, 1, 1, 5, 4, 8'h10, 0, 0, 0, 0);
        step(1, 1, 1, 5, 4, 8'h20, 0, 0, 0, 0);
        do_reset();
        step(1, 1, 0, 0, 7, 8'h11, 0, 0, 0, 0);
        chk("rst_level", level, 1);
        chk("rst_beats", rec_beats, 1);
        chk("rst_source", rec_source, 7);
        idle(1, 0);
        chk("rst_one_record", level, 0);

        // Randomized traffic with varying drain pressure
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) pct = $urandom_range(5, 95);
            if ($urandom_range(0, 799) == 0) do_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 7), $urandom_range(0, 8),
                 $urandom_range(0, 15), $urandom_range(0, 255),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 99) < pct, $urandom_range(0, 24) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
